// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_responder
// Description : Memory-side responder for the sm83 core bus. Decodes every
//               CPU access, returns read data combinationally, and routes
//               writes. Owns HRAM (FF80-FFFE), IE (FFFF) and the OAM DMA
//               engine (FF46). Other regions go out on the ext, OAM and IO
//               ports.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DMA_LEN    bytes copied per OAM DMA transfer (1..256)
//   DMA_ARM    ce cycles between the FF46 write and the first DMA byte (1..256)
//   UNMAP_VAL  read value returned for FEA0-FEFF
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active low
//   ce         in   1   cycle enable; state advances only on ce edges
//   cpu_addr   in  16   CPU address
//   cpu_wdata  in   8   CPU write data
//   cpu_write  in   1   CPU write request
//   cpu_rdata  out  8   CPU read data, combinational from cpu_addr
//   ext_addr   out 16   ext address (ROM/VRAM/cart RAM/WRAM)
//   ext_wdata  out  8   ext write data
//   ext_rdata  in   8   ext read data, same cycle
//   ext_we     out  1   ext write strobe, ce-qualified
//   oam_addr   out  8   OAM byte index
//   oam_wdata  out  8   OAM write data
//   oam_rdata  in   8   OAM read data, same cycle
//   oam_we     out  1   OAM write strobe, ce-qualified
//   io_addr    out  7   IO register offset (FF00 + io_addr)
//   io_wdata   out  8   IO write data
//   io_rdata   in   8   IO read data, same cycle
//   io_we      out  1   IO write strobe, ce-qualified, never for FF46
//   dma_busy   out  1   high while the DMA engine is armed or copying
// ============================================================================
module bus_responder #(
    parameter int         DMA_LEN   = 160,
    parameter int         DMA_ARM   = 1,
    parameter logic [7:0] UNMAP_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        ext_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata,
    output logic        oam_we,
    output logic [6:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    output logic        io_we,
    output logic        dma_busy
);

    // ------------------------------------------------------------------
    // DMA state encoding and terminal counts
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);
    localparam logic [7:0] ARM_LAST = 8'(DMA_ARM - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [7:0] dma_src;
    logic [7:0] dma_idx;
    logic [7:0] arm_cnt;
    logic [4:0] ie;
    logic [7:0] hram [0:126];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic hit_ext;
    logic hit_oam;
    logic hit_unmap;
    logic hit_dma_reg;
    logic hit_io;
    logic hit_hram;
    logic hit_ie;

    assign hit_ext     = (cpu_addr < 16'hFE00);
    assign hit_oam     = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    assign hit_unmap   = (cpu_addr >= 16'hFEA0) && (cpu_addr <= 16'hFEFF);
    assign hit_dma_reg = (cpu_addr == 16'hFF46);
    // FF00-FF7F share the upper nine address bits 9'h1FE.
    assign hit_io      = (cpu_addr[15:7] == 9'h1FE) && !hit_dma_reg;
    // FF80-FFFF share 9'h1FF; the last byte of that window is IE.
    assign hit_hram    = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
    assign hit_ie      = (cpu_addr == 16'hFFFF);

    // ------------------------------------------------------------------
    // Bus ownership
    // ------------------------------------------------------------------
    logic       dma_active;
    logic       cpu_wr;
    logic [7:0] dma_src_eff;
    logic [15:0] cpu_ext_addr;

    assign dma_active = (state == ST_ACTIVE);
    assign cpu_wr     = ce & cpu_write;

    // Sources in the echo window fold down onto WRAM (E0 -> C0, FF -> DF).
    assign dma_src_eff = (dma_src >= 8'hE0) ? (dma_src & 8'hDF) : dma_src;

    // Echo region E000-FDFF aliases C000-DDFF by dropping address bit 13.
    assign cpu_ext_addr = (cpu_addr >= 16'hE000) ? (cpu_addr & 16'hDFFF) : cpu_addr;

    // While copying, the DMA drives both ext and OAM ports; CPU accesses
    // below FF00 are locked out and their writes are dropped.
    assign ext_addr  = dma_active ? {dma_src_eff, dma_idx} : cpu_ext_addr;
    assign ext_wdata = cpu_wdata;
    assign ext_we    = cpu_wr & hit_ext & ~dma_active;

    assign oam_addr  = dma_active ? dma_idx   : cpu_addr[7:0];
    assign oam_wdata = dma_active ? ext_rdata : cpu_wdata;
    assign oam_we    = dma_active ? ce : (cpu_wr & hit_oam);

    assign io_addr   = cpu_addr[6:0];
    assign io_wdata  = cpu_wdata;
    assign io_we     = cpu_wr & hit_io;

    assign dma_busy  = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Read mux (no registered latency)
    // ------------------------------------------------------------------
    always_comb begin
        cpu_rdata = 8'hFF;
        if (hit_ext) begin
            cpu_rdata = dma_active ? 8'hFF : ext_rdata;
        end else if (hit_oam) begin
            cpu_rdata = dma_active ? 8'hFF : oam_rdata;
        end else if (hit_unmap) begin
            cpu_rdata = dma_active ? 8'hFF : UNMAP_VAL;
        end else if (hit_dma_reg) begin
            cpu_rdata = dma_src;
        end else if (hit_io) begin
            cpu_rdata = io_rdata;
        end else if (hit_hram) begin
            cpu_rdata = hram[cpu_addr[6:0]];
        end else if (hit_ie) begin
            // Only five interrupt sources exist; the upper bits read as 1.
            cpu_rdata = {3'b111, ie};
        end
    end

    // ------------------------------------------------------------------
    // HRAM and IE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 127; i++) begin
                hram[i] <= 8'h00;
            end
            ie <= 5'h00;
        end else if (ce) begin
            if (cpu_write && hit_hram) begin
                hram[cpu_addr[6:0]] <= cpu_wdata;
            end
            if (cpu_write && hit_ie) begin
                ie <= cpu_wdata[4:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // OAM DMA engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            dma_src <= 8'hFF;
            dma_idx <= 8'h00;
            arm_cnt <= 8'h00;
        end else if (ce) begin
            if (cpu_write && hit_dma_reg) begin
                // A write to FF46 (re)starts the transfer from any state.
                state   <= ST_ARM;
                dma_src <= cpu_wdata;
                dma_idx <= 8'h00;
                arm_cnt <= 8'h00;
            end else begin
                case (state)
                    ST_ARM: begin
                        if (arm_cnt == ARM_LAST) begin
                            state <= ST_ACTIVE;
                        end else begin
                            arm_cnt <= arm_cnt + 8'h01;
                        end
                    end
                    ST_ACTIVE: begin
                        if (dma_idx == IDX_LAST) begin
                            state   <= ST_IDLE;
                            dma_idx <= 8'h00;
                        end else begin
                            dma_idx <= dma_idx + 8'h01;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
